// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter between a FIFO read port (A) and a valid/ready source (B).
// Round-robin with a per-owner burst limit, one byte in flight, inter-byte gap and a done watchdog.
module uart_tx_sched #(
    parameter int BURST       = 16,
    parameter int GAP_CYCLES  = 2,
    parameter int WDOG_CYCLES = 8192
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Enable,
    input  logic        i_A_Empty,
    input  logic [7:0]  i_A_Data,
    output logic        o_A_Rinc,
    input  logic        i_B_Valid,
    input  logic [7:0]  i_B_Data,
    output logic        o_B_Ready,
    output logic        o_TX_DV,
    output logic [7:0]  o_TX_Byte,
    input  logic        i_TX_Active,
    input  logic        i_TX_Done,
    output logic        o_Grant,
    output logic        o_Busy,
    output logic        o_Timeout,
    output logic [15:0] o_A_Count,
    output logic [15:0] o_B_Count
);
    localparam int              WD_W      = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST   = WD_W'(WDOG_CYCLES - 1);
    localparam logic [7:0]      GAP_LAST  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
    localparam logic [7:0]      BURST_MAX = 8'(BURST);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_GAP} state_t;

    state_t          state_reg;
    logic            grant_reg;
    logic [7:0]      burst_reg;
    logic [7:0]      gap_reg;
    logic [WD_W-1:0] wdog_reg;
    logic            tx_dv_reg;
    logic [7:0]      tx_byte_reg;
    logic            timeout_reg;

    logic [1:0]      req;
    logic [7:0]      req_data [2];
    logic            winner_next;
    logic            issue_next;
    logic [1:0]      take;

    assign req         = {i_B_Valid, ~i_A_Empty};
    assign req_data[0] = i_A_Data;
    assign req_data[1] = i_B_Data;

    // The current owner keeps the line under contention until its burst is used up.
    always_comb begin
        winner_next = req[1];
        if (req == 2'b11) begin
            winner_next = (burst_reg < BURST_MAX) ? grant_reg : ~grant_reg;
        end
        issue_next = ~i_Reset & i_Enable & ~i_TX_Active & (|req) & (state_reg == ST_IDLE);
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [15:0] count_reg;

            assign take[gi] = issue_next & (winner_next == 1'(gi));

            always_ff @(posedge i_Clock) begin
                if (i_Reset) begin
                    count_reg <= '0;
                end else if (take[gi]) begin
                    count_reg <= count_reg + 16'd1;
                end
            end
        end
    endgenerate

    assign o_A_Rinc  = take[0];
    assign o_B_Ready = take[1];
    assign o_A_Count = g_port[0].count_reg;
    assign o_B_Count = g_port[1].count_reg;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_reg   <= ST_IDLE;
            grant_reg   <= 1'b0;
            burst_reg   <= '0;
            gap_reg     <= '0;
            wdog_reg    <= '0;
            tx_dv_reg   <= 1'b0;
            tx_byte_reg <= '0;
            timeout_reg <= 1'b0;
        end else begin
            tx_dv_reg   <= 1'b0;
            timeout_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (issue_next) begin
                        tx_byte_reg <= req_data[winner_next];
                        tx_dv_reg   <= 1'b1;
                        state_reg   <= ST_ISSUE;
                        if (winner_next != grant_reg) begin
                            grant_reg <= winner_next;
                            burst_reg <= 8'd1;
                        end else if (burst_reg != 8'hFF) begin
                            burst_reg <= burst_reg + 8'd1;
                        end
                    end
                end
                ST_ISSUE: begin
                    wdog_reg  <= '0;
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_TX_Done) begin
                        gap_reg   <= '0;
                        state_reg <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    end else if (wdog_reg == WD_LAST) begin
                        // Abandon the lost done; the byte was already handed over and counted.
                        timeout_reg <= 1'b1;
                        gap_reg     <= '0;
                        state_reg   <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    end else begin
                        wdog_reg <= wdog_reg + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_reg == GAP_LAST) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        gap_reg <= gap_reg + 8'd1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign o_TX_DV   = tx_dv_reg;
    assign o_TX_Byte = tx_byte_reg;
    assign o_Grant   = grant_reg;
    assign o_Busy    = (state_reg != ST_IDLE);
    assign o_Timeout = timeout_reg;
endmodule
